// File: rtl/add_op_issuer.sv
// add_op_issuer: initiator-side driver for the two-cycle pipelined adder.
// Buffers operand pairs, issues each pair with a start pulse and a two-cycle
// hold on a/b, and collects adder results into a downstream result FIFO.
// Issue is credit-limited so the result FIFO can never overflow.
// Optional feature macro: ADD_ISSUER_CHECK_EN (shadow sum check drives err).
module add_op_issuer #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic         res_valid,
    input  logic [W-1:0] res_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         busy,
    output logic         err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t         state_q;
    logic           start_q;
    logic [W-1:0]   a_q, b_q;

    logic [W-1:0]   opa_mem_q [DEPTH];
    logic [W-1:0]   opb_mem_q [DEPTH];
    logic [AW-1:0]  op_wr_q, op_rd_q, head_idx;
    logic [CW-1:0]  op_cnt_q, op_cnt_d;

    logic [W-1:0]   res_mem_q [DEPTH];
    logic [AW-1:0]  res_wr_q, res_rd_q;
    logic [CW-1:0]  res_cnt_q, res_cnt_d;

    logic [CW-1:0]  outst_q, outst_d;
    logic [CW:0]    inflight;
    logic           credit, issue_go;
    logic           op_push, op_pop, res_acc, res_pop;

    assign op_push  = in_valid && in_ready;
    assign op_pop   = (state_q == S_HOLD);
    assign res_acc  = res_valid && (outst_q != '0);
    assign res_pop  = out_valid && out_ready;

    // Results already buffered plus results still in the adder must fit the result FIFO.
    assign inflight = {1'b0, res_cnt_q} + {1'b0, outst_q};
    assign credit   = inflight < (CW+1)'(DEPTH);

    // In HOLD the current head is being popped, so the next op is one entry further.
    assign head_idx = (state_q == S_HOLD) ? op_rd_q + AW'(1) : op_rd_q;

    assign op_cnt_d  = op_cnt_q + CW'(op_push) - CW'(op_pop);
    assign res_cnt_d = res_cnt_q + CW'(res_acc) - CW'(res_pop);
    assign outst_d   = outst_q + CW'(issue_go) - CW'(res_acc);

    assign in_ready  = (op_cnt_q != CW'(DEPTH));
    assign out_valid = (res_cnt_q != '0);
    assign out_y     = res_mem_q[res_rd_q];
    assign busy      = (op_cnt_q != '0) || (state_q != S_IDLE) || (outst_q != '0);
    assign start     = start_q;
    assign a         = a_q;
    assign b         = b_q;

    // Decide whether the next cycle is an ISSUE cycle.
    always_comb begin
        issue_go = 1'b0;
        case (state_q)
            S_IDLE:  issue_go = (op_cnt_q != '0) && credit;
            S_HOLD:  issue_go = (op_cnt_q >= CW'(2)) && credit;
            default: issue_go = 1'b0;
        endcase
    end

    // Operand FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                opa_mem_q[i] <= '0;
                opb_mem_q[i] <= '0;
            end
            op_wr_q  <= '0;
            op_rd_q  <= '0;
            op_cnt_q <= '0;
        end else begin
            if (op_push) begin
                opa_mem_q[op_wr_q] <= in_a;
                opb_mem_q[op_wr_q] <= in_b;
                op_wr_q            <= op_wr_q + AW'(1);
            end
            if (op_pop) op_rd_q <= op_rd_q + AW'(1);
            op_cnt_q <= op_cnt_d;
        end
    end

    // Issue sequencer: start pulse for one cycle, a/b held through the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (issue_go) begin
                        state_q <= S_ISSUE;
                        start_q <= 1'b1;
                        a_q     <= opa_mem_q[head_idx];
                        b_q     <= opb_mem_q[head_idx];
                    end else begin
                        state_q <= S_IDLE;
                        start_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_HOLD;
                    start_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    // Ops issued to the adder whose result has not yet come back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst_q <= '0;
        else        outst_q <= outst_d;
    end

    // Result FIFO; results arriving with nothing outstanding are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) res_mem_q[i] <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (res_acc) begin
                res_mem_q[res_wr_q] <= res_y;
                res_wr_q            <= res_wr_q + AW'(1);
            end
            if (res_pop) res_rd_q <= res_rd_q + AW'(1);
            res_cnt_q <= res_cnt_d;
        end
    end

`ifdef ADD_ISSUER_CHECK_EN
    logic [W-1:0]  exp_mem_q [DEPTH];
    logic [AW-1:0] ex_wr_q, ex_rd_q;
    logic          err_q;

    // Shadow FIFO of expected sums; its occupancy tracks outst_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) exp_mem_q[i] <= '0;
            ex_wr_q <= '0;
            ex_rd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (issue_go) begin
                exp_mem_q[ex_wr_q] <= opa_mem_q[head_idx] + opb_mem_q[head_idx];
                ex_wr_q            <= ex_wr_q + AW'(1);
            end
            if (res_acc) begin
                ex_rd_q <= ex_rd_q + AW'(1);
                if (res_y != exp_mem_q[ex_rd_q]) err_q <= 1'b1;
            end
            if (res_valid && (outst_q == '0)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_add_op_issuer.sv
// Directed testbench for add_op_issuer with a behavioural two-cycle adder.
module tb_add_op_issuer;
    localparam int W     = 10;
    localparam int DEPTH = 4;
`ifdef ADD_ISSUER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic         start;
    logic [W-1:0] a, b;
    logic         res_valid;
    logic [W-1:0] res_y;
    logic         out_valid, out_ready;
    logic [W-1:0] out_y;
    logic         busy, err;

    int nvec = 0;
    int nerr = 0;

    // adder model: registered a, live b, result valid two edges after start
    logic         add_v1, add_v2;
    logic [W-1:0] add_a1, add_y;
    logic [W-1:0] corrupt;
    logic         spur;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_v1 <= 1'b0; add_v2 <= 1'b0; add_a1 <= '0; add_y <= '0;
        end else begin
            add_v1 <= start;
            add_a1 <= a;
            add_v2 <= add_v1;
            add_y  <= (add_a1 + b) ^ corrupt;
        end
    end
    assign res_valid = add_v2 | spur;
    assign res_y     = add_y;

    add_op_issuer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .start(start), .a(a), .b(b),
        .res_valid(res_valid), .res_y(res_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .busy(busy), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        corrupt = 0; spur = 0;
        #3;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %0d exp 1", in_ready); end
        nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL reset_start got %0d exp 0", start); end
        nvec++; if (a !== '0 || b !== '0) begin nerr++; $display("FAIL reset_ab got %0d/%0d exp 0/0", a, b); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
        nvec++; if (out_y !== '0) begin nerr++; $display("FAIL reset_out_y got %0d exp 0", out_y); end
        nvec++; if (busy !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL reset_busy_err got %0d/%0d exp 0/0", busy, err); end
        tick(); rst_n = 1'b1; tick();
        nvec++; if (start !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL post_reset_idle got %0d/%0d exp 0/0", start, busy); end
    endtask

    task automatic test_single();
        out_ready = 0;
        in_valid = 1; in_a = 3; in_b = 4;
        tick(); in_valid = 0;                           // E0
        nvec++; if (start !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL single_e0 start/busy got %0d/%0d exp 0/1", start, busy); end
        tick();                                          // E1
        nvec++; if (start !== 1'b1 || a !== 10'd3 || b !== 10'd4) begin nerr++; $display("FAIL single_e1 start/a/b got %0d/%0d/%0d exp 1/3/4", start, a, b); end
        tick();                                          // E2
        nvec++; if (start !== 1'b0 || a !== 10'd3 || b !== 10'd4) begin nerr++; $display("FAIL single_e2 start/a/b got %0d/%0d/%0d exp 0/3/4", start, a, b); end
        tick();                                          // E3
        nvec++; if (out_valid !== 1'b0 || a !== 10'd3 || b !== 10'd4) begin nerr++; $display("FAIL single_e3 out_valid/a/b got %0d/%0d/%0d exp 0/3/4", out_valid, a, b); end
        tick();                                          // E4
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd7) begin nerr++; $display("FAIL single_e4 out_valid/out_y got %0d/%0d exp 1/7", out_valid, out_y); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy got %0d exp 0", busy); end
        out_ready = 1; tick(); out_ready = 0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_pop out_valid got %0d exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        out_ready = 0;
        in_valid = 1; in_a = 10'd1023; in_b = 10'd1;
        tick();
        in_a = 10'd1023; in_b = 10'd1023;
        tick(); in_valid = 0;
        for (int i = 0; i < 10; i++) tick();
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd0) begin nerr++; $display("FAIL wrap_first got %0d/%0d exp 1/0", out_valid, out_y); end
        out_ready = 1; tick();
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd1022) begin nerr++; $display("FAIL wrap_second got %0d/%0d exp 1/1022", out_valid, out_y); end
        tick(); out_ready = 0;
        nvec++; if (out_valid !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL wrap_drain out_valid/err got %0d/%0d exp 0/0", out_valid, err); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] opa [4];
        logic [W-1:0] opb [4];
        logic [W-1:0] sums [4];
        int r;
        opa = '{10'd10, 10'd100, 10'd511, 10'd7};
        opb = '{10'd20, 10'd200, 10'd1, 10'd8};
        sums = '{10'd30, 10'd300, 10'd512, 10'd15};
        r = 0;
        out_ready = 1;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin in_valid = 1; in_a = opa[k]; in_b = opb[k]; end
            else in_valid = 0;
            tick();                                      // now just after E_k
            nvec++;
            if (start !== (k == 1 || k == 3 || k == 5 || k == 7)) begin
                nerr++; $display("FAIL b2b_start edge %0d got %0d", k, start);
            end
            nvec++;
            if (out_valid !== (k == 4 || k == 6 || k == 8 || k == 10)) begin
                nerr++; $display("FAIL b2b_out_valid edge %0d got %0d", k, out_valid);
            end
            if (out_valid === 1'b1 && r < 4) begin
                nvec++;
                if (out_y !== sums[r]) begin nerr++; $display("FAIL b2b_out_y idx %0d got %0d exp %0d", r, out_y, sums[r]); end
                r++;
            end
        end
        out_ready = 0;
        nvec++; if (r !== 4 || busy !== 1'b0) begin nerr++; $display("FAIL b2b_count got %0d busy %0d exp 4 busy 0", r, busy); end
    endtask

    task automatic test_backpressure();
        int idx, ridx, nstart;
        logic acc;
        logic [W-1:0] exp_y;
        idx = 0; ridx = 0; nstart = 0;
        out_ready = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (idx < 10);
            in_a = W'(idx * 100 + 5); in_b = 10'd200;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (start === 1'b1) nstart++;
        end
        in_valid = 0;
        nvec++; if (nstart !== 4) begin nerr++; $display("FAIL bp_issued got %0d exp 4", nstart); end
        nvec++; if (idx !== 8) begin nerr++; $display("FAIL bp_accepted got %0d exp 8", idx); end
        nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            nerr++; $display("FAIL bp_stall in_ready/out_valid/busy got %0d/%0d/%0d exp 0/1/1", in_ready, out_valid, busy);
        end
        out_ready = 1;
        for (int c = 0; c < 100 && ridx < 10; c++) begin
            in_valid = (idx < 10);
            in_a = W'(idx * 100 + 5); in_b = 10'd200;
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                exp_y = W'((ridx * 100 + 205) % 1024);
                nvec++;
                if (out_y !== exp_y) begin nerr++; $display("FAIL bp_drain idx %0d got %0d exp %0d", ridx, out_y, exp_y); end
                ridx++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 0; out_ready = 0;
        tick(); tick();
        nvec++; if (ridx !== 10 || idx !== 10) begin nerr++; $display("FAIL bp_total results %0d accepted %0d exp 10/10", ridx, idx); end
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL bp_empty out_valid/busy got %0d/%0d exp 0/0", out_valid, busy); end
    endtask

    task automatic test_check();
        out_ready = 0;
        spur = 1; tick(); spur = 0;
        nvec++; if (err !== EXP_ERR) begin nerr++; $display("FAIL spur_err got %0d exp %0d", err, EXP_ERR); end
        tick();
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL spur_no_push out_valid/busy got %0d/%0d exp 0/0", out_valid, busy); end
        do_reset();
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL check_reset_err got %0d exp 0", err); end
        corrupt = 10'h001;
        in_valid = 1; in_a = 10'd5; in_b = 10'd5;
        tick(); in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd11) begin nerr++; $display("FAIL corrupt_result got %0d/%0d exp 1/11", out_valid, out_y); end
        nvec++; if (err !== EXP_ERR) begin nerr++; $display("FAIL corrupt_err got %0d exp %0d", err, EXP_ERR); end
        corrupt = '0;
        out_ready = 1; tick(); out_ready = 0;
        in_valid = 1; in_a = 10'd2; in_b = 10'd3;
        tick(); in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd5) begin nerr++; $display("FAIL clean_result got %0d/%0d exp 1/5", out_valid, out_y); end
        nvec++; if (err !== EXP_ERR) begin nerr++; $display("FAIL sticky_err got %0d exp %0d", err, EXP_ERR); end
        out_ready = 1; tick(); out_ready = 0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        in_valid = 1; in_a = 10'd1; in_b = 10'd1; tick();   // E0
        in_a = 10'd2; in_b = 10'd2; tick();                  // E1
        in_a = 10'd3; in_b = 10'd3; tick();                  // E2
        in_valid = 0; tick(); tick();                        // E4: HOLD, first result buffered
        nvec++; if (busy !== 1'b1 || out_valid !== 1'b1) begin nerr++; $display("FAIL mid_pre busy/out_valid got %0d/%0d exp 1/1", busy, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (start !== 1'b0 || a !== '0 || b !== '0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL mid_reset start/a/b/in_ready got %0d/%0d/%0d/%0d exp 0/0/0/1", start, a, b, in_ready);
        end
        nvec++; if (out_valid !== 1'b0 || out_y !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            nerr++; $display("FAIL mid_reset out_valid/out_y/busy/err got %0d/%0d/%0d/%0d exp 0/0/0/0", out_valid, out_y, busy, err);
        end
        tick(); rst_n = 1'b1; tick();
        in_valid = 1; in_a = 10'd5; in_b = 10'd6;
        tick(); in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (out_valid !== 1'b1 || out_y !== 10'd11) begin nerr++; $display("FAIL mid_after got %0d/%0d exp 1/11", out_valid, out_y); end
        out_ready = 1; tick(); out_ready = 0;
        tick(); tick(); tick();
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL mid_no_stale out_valid/busy got %0d/%0d exp 0/0", out_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
